// File: rtl/chk_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chk_arb_pkg
// Purpose  : Shared types and character constants for the checker stream
//            arbiter: the arbiter state encoding and the framing characters
//            of a trace record ('^' start, '#' end, NUL idle filler).
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package chk_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_REPORT = 3'd3,
        ST_FLUSH  = 3'd4
    } arb_state_t;

    localparam logic [7:0] CH_START = 8'h5E;  // '^'
    localparam logic [7:0] CH_END   = 8'h23;  // '#'
    localparam logic [7:0] CH_NUL   = 8'h00;  // idle filler, resyncs the checker

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin priority pick. Returns the first set
//            request bit found scanning upward (with wrap) from ptr.
// Ports    : req [N]   request vector
//            ptr [IDW] index with highest priority
//            hit       at least one request set
//            idx [IDW] index of the winning request (0 when no hit)
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           hit,
    output logic [IDW-1:0] idx
);

    // Scan offsets from farthest to nearest so the nearest requester
    // (smallest offset from ptr) is the last one written and wins.
    always_comb begin
        int cand;
        hit  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand[IDW-1:0]]) begin
                hit = 1'b1;
                idx = cand[IDW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/checker_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : checker_stream_arbiter
// Purpose  : Shares one cpu_checker between N character sources. A source is
//            granted for a whole record ('^' .. '#'), its characters are
//            forwarded one per cycle through a register onto chk_char, and
//            the checker verdict is sampled and returned tagged with the
//            source id. Stalls and overlength records end as aborts.
// Ports    : clk, reset (async, active low)
//            src_valid[N], src_char[8N] in  / src_ready[N] out (one-hot)
//            chk_char[8] out, chk_format_type[2], chk_error_code[4] in
//            res_valid, res_id, res_format, res_error, res_abort, busy out
// Revision : 1.0  initial release
// ============================================================================
module checker_stream_arbiter
    import chk_arb_pkg::*;
#(
    parameter int N       = 2,
    parameter int MAX_LEN = 40,
    parameter int CHK_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         src_valid,
    input  logic [8*N-1:0]       src_char,
    output logic [N-1:0]         src_ready,
    output logic [7:0]           chk_char,
    input  logic [1:0]           chk_format_type,
    input  logic [3:0]           chk_error_code,
    output logic                 res_valid,
    output logic [$clog2(N)-1:0] res_id,
    output logic [1:0]           res_format,
    output logic [3:0]           res_error,
    output logic                 res_abort,
    output logic                 busy
);

    localparam int IDW  = $clog2(N);
    localparam int LENW = $clog2(MAX_LEN + 1);
    localparam int LATW = $clog2(CHK_LAT + 2);

    arb_state_t      state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [LENW-1:0] len_q, len_d;
    logic [LATW-1:0] lat_q, lat_d;
    logic [7:0]      chk_char_q, chk_char_d;
    logic [1:0]      fmt_q, fmt_d;
    logic [3:0]      err_q, err_d;
    logic            abort_q, abort_d;

    logic            pick_hit;
    logic [IDW-1:0]  pick_idx;
    logic [7:0]      g_char;
    logic            g_valid;
    logic            len_full;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req (src_valid),
        .ptr (rr_q),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    assign g_char   = src_char[{grant_q, 3'b000} +: 8];
    assign g_valid  = src_valid[grant_q];
    assign len_full = (len_q == LENW'(MAX_LEN));

    // Ready is decoded from registered state only, so it falls on the edge
    // after '#' is taken and stays low once MAX_LEN characters are in.
    always_comb begin
        src_ready = '0;
        if (state_q == ST_FWD && !len_full) begin
            src_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        len_d      = len_q;
        lat_d      = lat_q;
        chk_char_d = CH_NUL;
        fmt_d      = fmt_q;
        err_d      = err_q;
        abort_d    = abort_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_hit) begin
                    grant_d = pick_idx;
                    len_d   = '0;
                    lat_d   = '0;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                // Overlength is tested before the stall so a full record
                // aborts even if the source has also dropped valid.
                if (len_full || !g_valid) begin
                    abort_d = 1'b1;
                    fmt_d   = '0;
                    err_d   = '0;
                    state_d = ST_REPORT;
                end else begin
                    chk_char_d = g_char;
                    len_d      = len_q + LENW'(1);
                    if (g_char == CH_END) begin
                        lat_d   = '0;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                // lat_q is 0 in the cycle '#' sits on chk_char.
                if (lat_q == LATW'(CHK_LAT)) begin
                    fmt_d   = chk_format_type;
                    err_d   = chk_error_code;
                    abort_d = 1'b0;
                    state_d = ST_REPORT;
                end else begin
                    lat_d = lat_q + LATW'(1);
                end
            end
            ST_REPORT: begin
                rr_d    = (grant_q == IDW'(N - 1)) ? '0 : grant_q + IDW'(1);
                state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_q       <= '0;
            len_q      <= '0;
            lat_q      <= '0;
            chk_char_q <= CH_NUL;
            fmt_q      <= '0;
            err_q      <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            len_q      <= len_d;
            lat_q      <= lat_d;
            chk_char_q <= chk_char_d;
            fmt_q      <= fmt_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
        end
    end

    assign chk_char   = chk_char_q;
    assign busy       = (state_q != ST_IDLE);
    assign res_valid  = (state_q == ST_REPORT);
    assign res_id     = res_valid ? grant_q : '0;
    assign res_format = res_valid ? fmt_q   : '0;
    assign res_error  = res_valid ? err_q   : '0;
    assign res_abort  = res_valid ? abort_q : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_checker_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_checker_stream_arbiter
// Purpose  : Self-checking bench for checker_stream_arbiter: table of single
//            records, hand sequences for reset and round-robin order, and
//            randomized multi-source traffic against a record-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_checker_stream_arbiter;

    localparam int N       = 2;
    localparam int MAX_LEN = 40;
    localparam int CHK_LAT = 1;

    typedef struct {int key; int len; int hash; int stall;} rec_t;
    typedef struct {int src; rec_t r; int exp_acc; int exp_abort;} vec_t;
    typedef struct {int id; int abort; int fmt; int err; int acc; int cyc; int hcyc;} obs_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [N-1:0]         src_valid;
    logic [8*N-1:0]       src_char;
    logic [N-1:0]         src_ready;
    logic [7:0]           chk_char;
    logic [1:0]           chk_format_type;
    logic [3:0]           chk_error_code;
    logic                 res_valid;
    logic [$clog2(N)-1:0] res_id;
    logic [1:0]           res_format;
    logic [3:0]           res_error;
    logic                 res_abort;
    logic                 busy;

    checker_stream_arbiter #(
        .N       (N),
        .MAX_LEN (MAX_LEN),
        .CHK_LAT (CHK_LAT)
    ) dut (
        .clk             (clk),
        .reset           (rst_n),
        .src_valid       (src_valid),
        .src_char        (src_char),
        .src_ready       (src_ready),
        .chk_char        (chk_char),
        .chk_format_type (chk_format_type),
        .chk_error_code  (chk_error_code),
        .res_valid       (res_valid),
        .res_id          (res_id),
        .res_format      (res_format),
        .res_error       (res_error),
        .res_abort       (res_abort),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int         n_vec   = 0;
    int         n_bad   = 0;
    int         cyc     = 0;
    int         hcyc    = 0;
    int         nul_run = 0;
    int         acc_src = -1;
    int         mp      = 0;
    logic [7:0] exp_char = 8'h00;
    rec_t       cur [N];
    bit         act [N];
    int         pos [N];
    int         acc_cnt [N];
    rec_t       pend [N][$];
    rec_t       expq [N][$];
    obs_t       obs_q [$];
    vec_t       tbl [10];

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_vec++;
        if (actual !== required) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    function automatic logic [1:0] fmt_at(int k);
        return 2'(k);
    endfunction

    function automatic logic [3:0] err_at(int k);
        return 4'(k * 5 + 3);
    endfunction

    // Character j of a record: '^' first, '#' at the hash index, otherwise
    // either the reference trace text or printable filler that is never '#'.
    function automatic logic [7:0] char_of(rec_t r, int j);
        string s = "^1024@00003000: $05 <= 00000000";
        int    k = (r.key < 0) ? 0 : r.key;
        if (j == r.hash) return 8'h23;
        if (j == 0) return 8'h5E;
        if (r.key < 0 && j < s.len()) return s[j];
        return 8'h30 + 8'((k * 13 + j * 7) % 40);
    endfunction

    // Record-level outcome: the record ends at '#', at the first character
    // the source does not offer, or after MAX_LEN characters.
    task automatic expect_of(input rec_t r, output int acc, output int ab);
        int s = (r.stall >= 0 && r.stall < r.len) ? r.stall : r.len;
        if (r.hash >= 0 && r.hash < s && r.hash < MAX_LEN) begin
            acc = r.hash + 1;
            ab  = 0;
        end else begin
            acc = (s < MAX_LEN) ? s : MAX_LEN;
            ab  = 1;
        end
    endtask

    task automatic load(input int i, input rec_t r);
        if (!act[i]) begin
            cur[i]     = r;
            act[i]     = 1'b1;
            pos[i]     = 0;
            acc_cnt[i] = 0;
        end else begin
            pend[i].push_back(r);
        end
    endtask

    task automatic clear_bench();
        for (int i = 0; i < N; i++) begin
            act[i]     = 1'b0;
            pos[i]     = 0;
            acc_cnt[i] = 0;
            pend[i].delete();
            expq[i].delete();
        end
        acc_src  = -1;
        exp_char = 8'h00;
        mp       = 0;
    endtask

    task automatic tick();
        logic [N-1:0]   v;
        logic [8*N-1:0] c;
        obs_t           o;
        @(negedge clk);
        cyc++;
        chk("chk_char", chk_char, exp_char);
        chk("ready_onehot", $onehot0(src_ready), 1);
        if (chk_char == 8'h00) begin
            nul_run++;
        end else begin
            if (nul_run != 0) chk("nul_gap_ge2", nul_run >= 2, 1);
            nul_run = 0;
        end
        if (acc_src >= 0) begin
            pos[acc_src]++;
            acc_cnt[acc_src]++;
        end
        if (chk_char == 8'h23) hcyc = cyc;
        if (res_valid === 1'b1) begin
            o.id    = int'(res_id);
            o.abort = int'(res_abort);
            o.fmt   = int'(res_format);
            o.err   = int'(res_error);
            o.acc   = acc_cnt[res_id];
            o.cyc   = cyc;
            o.hcyc  = hcyc;
            obs_q.push_back(o);
            act[res_id]     = 1'b0;
            acc_cnt[res_id] = 0;
            if (pend[res_id].size() > 0) load(int'(res_id), pend[res_id].pop_front());
        end
        for (int i = 0; i < N; i++) begin
            if (act[i] && pos[i] < cur[i].len && pos[i] != cur[i].stall) begin
                v[i]         = 1'b1;
                c[8*i +: 8]  = char_of(cur[i], pos[i]);
            end else begin
                v[i]         = 1'b0;
                c[8*i +: 8]  = 8'($urandom);
            end
        end
        src_valid       = v;
        src_char        = c;
        chk_format_type = fmt_at(cyc);
        chk_error_code  = err_at(cyc);
        #1;
        acc_src  = -1;
        exp_char = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (src_valid[i] && src_ready[i]) begin
                acc_src  = i;
                exp_char = src_char[8*i +: 8];
            end
        end
    endtask

    task automatic run_until(input int target, input int budget);
        int b = 0;
        while (obs_q.size() < target && b < budget) begin
            tick();
            b++;
        end
        if (obs_q.size() < target) chk("result_timeout", obs_q.size(), target);
    endtask

    task automatic check_rec(input int exp_id, input int exp_acc, input int exp_abort);
        obs_t o;
        if (obs_q.size() == 0) begin
            chk("result_missing", 0, 1);
            return;
        end
        o = obs_q.pop_front();
        chk("res_id", o.id, exp_id);
        chk("res_abort", o.abort, exp_abort);
        chk("chars_accepted", o.acc, exp_acc);
        if (exp_abort != 0) begin
            chk("res_format_abort", o.fmt, 0);
            chk("res_error_abort", o.err, 0);
        end else begin
            chk("res_format", o.fmt, fmt_at(o.hcyc + CHK_LAT));
            chk("res_error", o.err, err_at(o.hcyc + CHK_LAT));
            chk("res_latency", o.cyc - o.hcyc, CHK_LAT + 1);
        end
        mp = (exp_id + 1) % N;
    endtask

    function automatic int next_src();
        for (int k = 0; k < N; k++) begin
            if (expq[(mp + k) % N].size() > 0) return (mp + k) % N;
        end
        return 0;
    endfunction

    initial begin
        rec_t r;
        int   b;
        int   e_acc;
        int   e_ab;
        int   p;

        //             src  key len hash stall  acc abort
        tbl[0] = '{0, '{-1, 33, 31, -1}, 32, 0};  // reference trace line
        tbl[1] = '{1, '{ 7,  6,  4, -1},  5, 0};
        tbl[2] = '{1, '{-1,  8, -1,  3},  3, 1};  // stall after "^10"
        tbl[3] = '{0, '{ 9, 45, -1, -1}, 40, 1};  // overlength, 45 offered
        tbl[4] = '{1, '{11, 41, 39, -1}, 40, 0};  // '#' is the 40th char
        tbl[5] = '{1, '{12, 42, 40, -1}, 40, 1};  // '#' would be the 41st
        tbl[6] = '{0, '{13,  3,  1, -1},  2, 0};
        tbl[7] = '{1, '{14, 10,  8,  5},  5, 1};  // stall before '#'
        tbl[8] = '{1, '{15, 40, -1, -1}, 40, 1};  // full without '#'
        tbl[9] = '{0, '{16,  5,  4, -1},  5, 0};

        src_valid       = '0;
        src_char        = '0;
        chk_format_type = '0;
        chk_error_code  = '0;
        clear_bench();

        #2 rst_n = 1'b0;
        #1;
        chk("rst_chk_char", chk_char, 8'h00);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_format", res_format, 0);
        chk("rst_res_error", res_error, 0);
        chk("rst_res_abort", res_abort, 0);
        chk("rst_busy", busy, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        for (int t = 0; t < 10; t++) begin
            load(tbl[t].src, tbl[t].r);
            run_until(1, 200);
            check_rec(tbl[t].src, tbl[t].exp_acc, tbl[t].exp_abort);
        end

        // Reset in the middle of a record from source 1 while rr points at 1.
        r = '{5, 30, 25, -1};
        load(1, r);
        b = 0;
        while (acc_cnt[1] < 6 && b < 100) begin
            tick();
            b++;
        end
        chk("midrec_progress", acc_cnt[1] >= 6, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrec_rst_chk_char", chk_char, 8'h00);
        chk("midrec_rst_src_ready", src_ready, 0);
        chk("midrec_rst_busy", busy, 0);
        chk("midrec_rst_res_valid", res_valid, 0);
        clear_bench();
        repeat (2) tick();
        rst_n = 1'b1;
        chk("midrec_no_result", obs_q.size(), 0);

        // Both sources busy: grants must alternate starting from source 0.
        r = '{1,  6, 5, -1}; load(0, r);
        r = '{3,  8, 6, -1}; load(1, r);
        r = '{2, 10, 7, -1}; load(0, r);
        r = '{4, 12, 9, -1}; load(1, r);
        run_until(4, 400);
        check_rec(0, 6, 0);
        check_rec(1, 7, 0);
        check_rec(0, 8, 0);
        check_rec(1, 10, 0);

        // Randomized traffic, all sources loaded together.
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < 5; k++) begin
                    r.key   = int'($urandom_range(0, 999));
                    r.len   = int'($urandom_range(2, 46));
                    r.hash  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, r.len - 1)) : -1;
                    r.stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, r.len - 1)) : -1;
                    load(i, r);
                    expq[i].push_back(r);
                end
            end
            run_until(5 * N, 4000);
            for (int k = 0; k < 5 * N; k++) begin
                p = next_src();
                r = expq[p].pop_front();
                expect_of(r, e_acc, e_ab);
                check_rec(p, e_acc, e_ab);
            end
            repeat (4) tick();
        end

        chk("leftover_results", obs_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
